// File: rtl/fdiv_iter.sv
// Iterative IEEE-754 single-precision divider y = x1 / x2 (restoring, 1 quotient bit per cycle).
// Latency: 28 cycles from accept to valid_out for normal operands, 1 cycle for special operands.
// Backpressure: ready is high only in IDLE; valid_in while busy is dropped, not queued.
module fdiv_iter (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] x1,
   input  logic [31:0] x2,
   input  logic        valid_in,
   output logic        ready,
   output logic [31:0] y,
   output logic        ovf,
   output logic        valid_out
);

   typedef struct packed {
      logic        s;
      logic [7:0]  e;
      logic [22:0] m;
   } fp_t;

   typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} state_t;

   state_t state, state_nxt;

   fp_t a, b;
   assign a = x1;
   assign b = x2;

   logic [4:0]        cnt;
   logic [24:0]       rem;
   logic [23:0]       dvs;
   logic [25:0]       quo;
   logic              sy;
   logic signed [9:0] et;

   // special-operand decode, evaluated on the raw inputs so it can be resolved at accept
   logic        a_nan, a_inf, a_zero, b_nan, b_inf, b_zero, sy_in;
   logic        spec_hit, spec_ovf;
   logic [31:0] spec_y;

   // classify operands and pick the special-case result, if any
   always_comb begin
      a_nan    = (&a.e) & (|a.m);
      a_inf    = (&a.e) & ~(|a.m);
      a_zero   = ~(|a.e);
      b_nan    = (&b.e) & (|b.m);
      b_inf    = (&b.e) & ~(|b.m);
      b_zero   = ~(|b.e);
      sy_in    = a.s ^ b.s;
      spec_hit = 1'b1;
      spec_ovf = 1'b0;
      spec_y   = 32'h0;
      if (a_nan || b_nan) begin
         spec_y = 32'h7FC0_0000;
      end else if ((a_inf && b_inf) || (a_zero && b_zero)) begin
         spec_y = {1'b1, 8'hFF, 1'b1, 22'h0};
      end else if (a_inf) begin
         spec_y = {sy_in, 8'hFF, 23'h0};
      end else if (b_inf || a_zero) begin
         spec_y = {sy_in, 31'h0};
      end else if (b_zero) begin
         spec_y   = {sy_in, 8'hFF, 23'h0};
         spec_ovf = 1'b1;
      end else begin
         spec_hit = 1'b0;
      end
   end

   // one restoring-division step: trial subtract, keep the difference if non-negative
   logic        r_ge;
   logic [24:0] r_sub;

   // trial subtraction of the divisor from the partial remainder
   always_comb begin
      r_ge  = (rem >= {1'b0, dvs});
      r_sub = r_ge ? (rem - {1'b0, dvs}) : rem;
   end

   // normalize, round-to-nearest-even and range check of the finished quotient
   logic [23:0]       mant;
   logic              grd, stk, inc;
   logic [24:0]       mant_r;
   logic [22:0]       frac;
   logic signed [9:0] ex_n, ex_f;
   logic [31:0]       rnd_y;
   logic              rnd_ovf;

   // the quotient sits in [2^24, 2^26): its top bit decides the one-place normalize shift
   always_comb begin
      if (quo[25]) begin
         mant = quo[25:2];
         grd  = quo[1];
         stk  = quo[0] | (|rem);
         ex_n = et;
      end else begin
         mant = quo[24:1];
         grd  = quo[0];
         stk  = |rem;
         ex_n = et - 10'sd1;
      end
      inc    = grd & (stk | mant[0]);
      mant_r = {1'b0, mant} + {24'd0, inc};
      // a carry out of the hidden bit leaves 1.000..0, so the shifted fraction is zero
      frac   = mant_r[24] ? mant_r[23:1] : mant_r[22:0];
      ex_f   = ex_n + $signed({9'd0, mant_r[24]});
      rnd_ovf = 1'b0;
      if (ex_f >= 10'sd255) begin
         rnd_y   = {sy, 8'hFF, 23'h0};
         rnd_ovf = 1'b1;
      end else if (ex_f <= 10'sd0) begin
         rnd_y = {sy, 31'h0};
      end else begin
         rnd_y = {sy, ex_f[7:0], frac};
      end
   end

   // next-state and handshake outputs, all decoded from the current state
   always_comb begin
      state_nxt = state;
      ready     = 1'b0;
      valid_out = 1'b0;
      case (state)
         IDLE: begin
            ready = 1'b1;
            if (valid_in) state_nxt = spec_hit ? DONE : DIV;
         end
         DIV: begin
            if (cnt == 5'd25) state_nxt = ROUND;
         end
         ROUND: begin
            state_nxt = DONE;
         end
         DONE: begin
            valid_out = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // state register, operand capture, divide iterations and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= 5'd0;
         rem   <= 25'd0;
         dvs   <= 24'd0;
         quo   <= 26'd0;
         sy    <= 1'b0;
         et    <= 10'sd0;
         y     <= 32'h0;
         ovf   <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (valid_in) begin
                  sy <= sy_in;
                  if (spec_hit) begin
                     y   <= spec_y;
                     ovf <= spec_ovf;
                  end else begin
                     rem <= {2'b01, a.m};
                     dvs <= {1'b1, b.m};
                     quo <= 26'd0;
                     cnt <= 5'd0;
                     et  <= $signed({2'b00, a.e}) - $signed({2'b00, b.e}) + 10'sd127;
                  end
               end
            end
            DIV: begin
               quo <= {quo[24:0], r_ge};
               rem <= r_sub << 1;
               cnt <= (cnt == 5'd25) ? 5'd0 : cnt + 5'd1;
            end
            ROUND: begin
               y   <= rnd_y;
               ovf <= rnd_ovf;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fdiv_iter.sv
// Bench for fdiv_iter: directed cases, randomized operands against an arithmetic reference,
// continuous-valid handshake, and reset abort.
module tb_fdiv_iter;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] x1, x2;
   logic        valid_in;
   logic        ready;
   logic [31:0] y;
   logic        ovf;
   logic        valid_out;

   int n_cmp = 0;
   int n_err = 0;

   fdiv_iter dut (
      .clk       (clk),
      .rst       (rst),
      .x1        (x1),
      .x2        (x2),
      .valid_in  (valid_in),
      .ready     (ready),
      .y         (y),
      .ovf       (ovf),
      .valid_out (valid_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   // Reference: exact integer quotient of the significands, rounded by comparing
   // twice the remainder with the divisor (nearest, ties to even).
   task automatic ref_div(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] ry, output logic ro, output logic sp);
      logic   s;
      logic   nan1, nan2, inf1, inf2, z1, z2;
      longint n1, n2, q, r;
      int     ex;
      s    = a[31] ^ b[31];
      nan1 = (a[30:23] == 8'hFF) && (a[22:0] != 0);
      nan2 = (b[30:23] == 8'hFF) && (b[22:0] != 0);
      inf1 = (a[30:23] == 8'hFF) && (a[22:0] == 0);
      inf2 = (b[30:23] == 8'hFF) && (b[22:0] == 0);
      z1   = (a[30:23] == 8'h00);
      z2   = (b[30:23] == 8'h00);
      sp   = 1'b1;
      ro   = 1'b0;
      ry   = 32'h0;
      if (nan1 || nan2)                 ry = 32'h7FC00000;
      else if ((inf1 && inf2) || (z1 && z2)) ry = 32'hFFC00000;
      else if (inf1)                    ry = {s, 8'hFF, 23'h0};
      else if (inf2 || z1)              ry = {s, 31'h0};
      else if (z2) begin
         ry = {s, 8'hFF, 23'h0};
         ro = 1'b1;
      end else begin
         sp = 1'b0;
         n1 = longint'({1'b1, a[22:0]});
         n2 = longint'({1'b1, b[22:0]});
         ex = int'(a[30:23]) - int'(b[30:23]) + 127;
         if (n1 >= n2) begin
            q = (n1 << 23) / n2;
            r = (n1 << 23) % n2;
         end else begin
            q = (n1 << 24) / n2;
            r = (n1 << 24) % n2;
            ex = ex - 1;
         end
         if ((2 * r > n2) || ((2 * r == n2) && q[0])) q = q + 1;
         if (q == (longint'(1) << 24)) begin
            q  = longint'(1) << 23;
            ex = ex + 1;
         end
         if (ex >= 255) begin
            ry = {s, 8'hFF, 23'h0};
            ro = 1'b1;
         end else if (ex <= 0) begin
            ry = {s, 31'h0};
         end else begin
            ry = {s, ex[7:0], q[22:0]};
         end
      end
   endtask

   function automatic logic [31:0] rnd_norm();
      logic [7:0] e;
      e = 8'($urandom_range(90, 164));
      return {1'($urandom_range(0, 1)), e, 23'($urandom)};
   endfunction

   function automatic logic [31:0] rnd_wide();
      logic [7:0] e;
      e = 8'($urandom_range(1, 254));
      return {1'($urandom_range(0, 1)), e, 23'($urandom)};
   endfunction

   // One accepted operation: checks busy ready, latency, result, pulse width, hold.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ey, input logic eo, input string tag);
      logic [31:0] my;
      logic        mo, sp;
      int          k;
      ref_div(a, b, my, mo, sp);
      k = 0;
      while (ready !== 1'b1 && k < 40) begin
         @(negedge clk);
         k++;
      end
      chk({tag, " ready_idle"}, 32'(ready), 32'd1);
      x1 = a;
      x2 = b;
      valid_in = 1'b1;
      @(negedge clk);
      valid_in = 1'b0;
      x1 = $urandom;
      x2 = $urandom;
      k = 1;
      while (valid_out !== 1'b1 && k < 40) begin
         chk({tag, " ready_busy"}, 32'(ready), 32'd0);
         @(negedge clk);
         k++;
      end
      chk({tag, " latency"}, 32'(k), sp ? 32'd1 : 32'd28);
      chk({tag, " y"}, y, ey);
      chk({tag, " ovf"}, 32'(ovf), 32'(eo));
      @(negedge clk);
      chk({tag, " pulse_end"}, 32'(valid_out), 32'd0);
      chk({tag, " ready_back"}, 32'(ready), 32'd1);
      chk({tag, " y_hold"}, y, ey);
   endtask

   logic [31:0] ra, rb, ey;
   logic        eo, esp;
   logic [32:0] exp_q[$];
   logic [32:0] ent;
   int          n_acc, n_out, k;

   initial begin
      rst = 1'b1;
      valid_in = 1'b0;
      x1 = 32'h0;
      x2 = 32'h0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("reset ready", 32'(ready), 32'd1);
      chk("reset valid_out", 32'(valid_out), 32'd0);
      chk("reset y", y, 32'h0);
      chk("reset ovf", 32'(ovf), 32'd0);

      // directed cases
      run_op(32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, "1/1");
      run_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0, "1/3");
      run_op(32'h40C00000, 32'hC0000000, 32'hC0400000, 1'b0, "6/-2");
      run_op(32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1, "1/0");
      run_op(32'h00000000, 32'h00000000, 32'hFFC00000, 1'b0, "0/0");
      run_op(32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b0, "nan");
      run_op(32'h7F800000, 32'hFF800000, 32'hFFC00000, 1'b0, "inf/inf");
      run_op(32'hFF800000, 32'h40000000, 32'hFF800000, 1'b0, "inf/2");
      run_op(32'h40000000, 32'hFF800000, 32'h80000000, 1'b0, "2/inf");
      run_op(32'h80000000, 32'h40000000, 32'h80000000, 1'b0, "0/2");
      run_op(32'h7F000000, 32'h00800000, 32'h7F800000, 1'b1, "ovf_range");
      run_op(32'h00800000, 32'h4B000000, 32'h00000000, 1'b0, "flush");

      // randomized operands against the reference
      for (int i = 0; i < 24; i++) begin
         ra = (i % 4 == 3) ? rnd_wide() : rnd_norm();
         rb = (i % 4 == 3) ? rnd_wide() : rnd_norm();
         ref_div(ra, rb, ey, eo, esp);
         run_op(ra, rb, ey, eo, "rand");
      end

      // valid_in held high with changing operands: only IDLE-edge operands consumed
      n_acc = 0;
      n_out = 0;
      valid_in = 1'b1;
      for (int c = 0; c < 300; c++) begin
         if (valid_out === 1'b1) begin
            n_out++;
            if (exp_q.size() > 0) begin
               ent = exp_q.pop_front();
               chk("hs y", y, ent[31:0]);
               chk("hs ovf", 32'(ovf), 32'(ent[32]));
            end
         end
         x1 = ($urandom_range(0, 3) == 0) ? $urandom : rnd_norm();
         x2 = ($urandom_range(0, 3) == 0) ? $urandom : rnd_norm();
         if (ready === 1'b1) begin
            ref_div(x1, x2, ey, eo, esp);
            exp_q.push_back({eo, ey});
            n_acc++;
         end
         @(negedge clk);
      end
      valid_in = 1'b0;
      k = 0;
      while (exp_q.size() > 0 && k < 40) begin
         if (valid_out === 1'b1) begin
            n_out++;
            ent = exp_q.pop_front();
            chk("hs y", y, ent[31:0]);
            chk("hs ovf", 32'(ovf), 32'(ent[32]));
         end
         @(negedge clk);
         k++;
      end
      repeat (3) begin
         if (valid_out === 1'b1) n_out++;
         @(negedge clk);
      end
      chk("hs pulse_count", 32'(n_out), 32'(n_acc));
      chk("hs drained", 32'(exp_q.size()), 32'd0);

      // rst wins over a simultaneous valid_in in IDLE
      x1 = 32'h3F800000;
      x2 = 32'h00000000;
      valid_in = 1'b1;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      valid_in = 1'b0;
      chk("rst_vs_valid valid_out", 32'(valid_out), 32'd0);
      chk("rst_vs_valid ready", 32'(ready), 32'd1);

      // abort a division at cycle 10
      run_op(32'h40400000, 32'h3F800000, 32'h40400000, 1'b0, "pre_abort");
      x1 = 32'h40490FDB;
      x2 = 32'h3F000000;
      valid_in = 1'b1;
      @(negedge clk);
      valid_in = 1'b0;
      repeat (9) @(negedge clk);
      chk("abort busy", 32'(ready), 32'd0);
      rst = 1'b1;
      valid_in = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      valid_in = 1'b0;
      chk("abort ready", 32'(ready), 32'd1);
      chk("abort y", y, 32'h0);
      chk("abort ovf", 32'(ovf), 32'd0);
      n_out = 0;
      repeat (30) begin
         if (valid_out === 1'b1) n_out++;
         @(negedge clk);
      end
      chk("abort no_pulse", 32'(n_out), 32'd0);
      run_op(32'h40000000, 32'h40000000, 32'h3F800000, 1'b0, "after_abort");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fdiv_iter.md
# fdiv_iter

Iterative single-precision floating-point divider for the FPU, computing y = x1 / x2. It uses a 1-bit-per-cycle restoring mantissa divider behind a valid/ready handshake. It sits beside the pipelined add/sub and mul units in the FPU execute stage, and the core stalls on `ready` while a division is in flight. Number handling matches the rest of the FPU: denormals flush to zero, round-to-nearest-even, and an `ovf` flag.

## Interface
- No parameters.
- clk  in  1  clock, all state changes on posedge.
- rst  in  1  reset, synchronous, active-high.
- x1  in  32  dividend (IEEE-754 single).
- x2  in  32  divisor (IEEE-754 single).
- valid_in  in  1  operands present; accepted on a posedge where valid_in & ready.
- ready  out  1  high only in IDLE.
- y  out  32  quotient; holds the last result until the next result.
- ovf  out  1  overflow / divide-by-zero flag for y; held with y.
- valid_out  out  1  one-cycle pulse marking y/ovf as new.

## Operation
- Unpacking:
  - e==0 means the operand is zero (mantissa ignored).
  - Significand is {1, m} (24 bits).
  - Sign of the result: sy = s1 ^ s2.
- Special cases are resolved at accept; the FSM goes straight to DONE.
  - Either operand NaN (e==255, m!=0) -> 0x7FC00000, ovf=0.
  - inf/inf or 0/0 -> {1,8'd255,1,22'b0}, ovf=0.
  - inf/finite -> {sy,255,0}, ovf=0.
  - finite/inf -> {sy,0,0}, ovf=0.
  - 0/nonzero -> {sy,0,0}, ovf=0.
  - nonzero/0 -> {sy,255,0}, ovf=1.
- Normal path:
  - Exponent: signed 10-bit et = e1 - e2 + 127.
  - Division: remainder r = {1,m1}, divisor d = {1,m2}. Each DIV cycle: if r >= d then q bit = 1 and r -= d, else q bit = 0; then r <<= 1.
  - This produces 26 quotient bits q[25:0], MSB first. The quotient lies in [2^24, 2^26).
- Normalize:
  - If q[25]=1: mantissa = q[25:2], guard = q[1], sticky = q[0] | (r!=0), exponent = et.
  - Else: mantissa = q[24:1], guard = q[0], sticky = (r!=0), exponent = et - 1.
- Round (RNE): increment when guard & (sticky | mantissa[0]). On carry out of bit 24, mantissa = 0x800000 and exponent += 1.
- Range:
  - Final exponent >= 255 -> {sy,255,0}, ovf=1.
  - Final exponent <= 0 -> {sy,0,0}, ovf=0 (flush).
  - Otherwise {sy, exponent[7:0], mantissa[22:0]}, ovf=0.
- FSM states and transitions:
  - IDLE -> DIV on accept of a normal operand pair; IDLE -> DONE on accept of a special pair.
  - DIV: 5-bit counter runs 0..25; leaves for ROUND after the 26th iteration.
  - ROUND -> DONE (normalize, round, range check; y/ovf registered here).
  - DONE -> IDLE. valid_out=1 for this cycle only; y/ovf are valid from this cycle.
- Operands are latched at accept, so x1/x2 may change afterward. valid_in while ready=0 (including in DONE) is ignored and not queued.

## Timing
- Reset values: state IDLE, ready=1, valid_out=0, y=32'h0, ovf=0, counter=0.
- Let accept edge = cycle 0.
  - Normal: DIV in cycles 1-26, ROUND in cycle 27, valid_out=1 in cycle 28. Next accept is possible at the end of cycle 29 (IDLE).
  - Special: valid_out=1 in cycle 1; IDLE in cycle 2.
- Throughput: one normal division every 29 cycles with back-to-back valid_in.
- rst during DIV, ROUND or DONE:
  - Aborts the operation and forces all reset values next cycle.
  - No valid_out pulse for the aborted operation.
  - rst wins over a simultaneous valid_in.
- y/ovf change only in the cycle valid_out rises (or on reset).

## Test plan
- 0x3F800000 / 0x3F800000 -> y=0x3F800000, ovf=0, valid_out high exactly 28 cycles after accept, ready low cycles 1-28.
- 0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAB (rounds up); 0x40C00000 / 0xC0000000 -> 0xC0400000.
- 0x3F800000 / 0x00000000 -> 0x7F800000, ovf=1 at cycle 1; 0x00000000 / 0x00000000 -> 0xFFC00000, ovf=0; 0x7FC00001 / 0x3F800000 -> 0x7FC00000.
- Range: 0x7F000000 / 0x00800000 -> 0x7F800000 with ovf=1 at cycle 28; 0x00800000 / 0x4B000000 -> 0x00000000 (flush), ovf=0.
- Handshake:
  - Hold valid_in high continuously with changing x1/x2.
  - Only operands present at IDLE edges are consumed.
  - Results match those operands, with no extra valid_out pulses.
- Reset: assert rst at cycle 10 of a division -> next cycle ready=1, y=0, ovf=0; no valid_out at cycle 28. A fresh 0x40000000/0x40000000 then returns 0x3F800000.
